// File: rtl/fde_pkg.sv
// Shared definitions for the fetch/decode/execute pipeline: EX_WB bus layout and writeback FSM states.
package fde_pkg;

  localparam int EX_WB_W     = 71;
  localparam int REG_ADDR_W  = 5;

  localparam int WB_DATA_LSB = 0;
  localparam int WB_DATA_MSB = 31;
  localparam int WB_PC_LSB   = 32;
  localparam int WB_PC_MSB   = 63;
  localparam int WB_DEST_LSB = 64;
  localparam int WB_DEST_MSB = 68;
  localparam int WB_BR_BIT   = 69;
  localparam int WB_EN_BIT   = 70;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic        wb_en;
    logic        br;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] data;
  } ex_wb_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } wb_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports with same-cycle write bypass, r0 reads 0.
// Latency: write visible through bypass in the writing cycle, from storage afterwards.
// Backpressure: none; a write request is always taken.
module regfile_2r1w
  import fde_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = REG_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_commit;

  // r0 is never written, so its storage stays at the reset value of zero.
  assign wr_commit = wr_vld && (wr_addr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_dat;
    end
  end

  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == '0)                       rs_data = '0;
    else if (wr_commit && wr_addr == rs_addr) rs_data = wr_dat;
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == '0)                       rt_data = '0;
    else if (wr_commit && wr_addr == rt_addr) rt_data = wr_dat;
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits EX_WB results, redirects fetch on taken branches, then squashes wrong-path entries.
// Latency: register write same edge as accept; pc_redirect/squashing one cycle after the branch is accepted.
// Backpressure: none; every ex_valid cycle is consumed (committed or discarded).
module writeback_stage
  import fde_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [EX_WB_W-1:0]    EX_WB,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic                  pc_redirect,
  output logic [31:0]           pc_target,
  output logic                  squashing,
  output logic [31:0]           retire_count
);

  localparam int SQ_W = (SQUASH_DEPTH < 2) ? 1 : $clog2(SQUASH_DEPTH + 1);

  ex_wb_t      ex;
  wb_state_t   state, state_nxt;
  logic [SQ_W-1:0] sq_cnt, sq_cnt_nxt;
  logic        redirect_nxt;
  logic [31:0] target_nxt;
  logic [31:0] retire_nxt;
  logic        accept;

  assign ex        = ex_wb_t'(EX_WB);
  assign accept    = ex_valid && (state == RUN) && !reset;
  assign squashing = (state == SQUASH);

  regfile_2r1w #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (REG_ADDR_W)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .wr_vld  (accept && ex.wb_en),
    .wr_addr (ex.dest),
    .wr_dat  (DATA_W'(ex.data)),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      sq_cnt       <= '0;
      pc_redirect  <= 1'b0;
      pc_target    <= '0;
      retire_count <= '0;
    end else begin
      state        <= state_nxt;
      sq_cnt       <= sq_cnt_nxt;
      pc_redirect  <= redirect_nxt;
      pc_target    <= target_nxt;
      retire_count <= retire_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sq_cnt_nxt   = sq_cnt;
    redirect_nxt = 1'b0;
    target_nxt   = pc_target;
    retire_nxt   = retire_count;
    case (state)
      RUN: begin
        if (accept) begin
          retire_nxt = retire_count + 32'd1;
          if (ex.br) begin
            redirect_nxt = 1'b1;
            target_nxt   = ex.pc;
            if (SQUASH_DEPTH > 0) begin
              sq_cnt_nxt = SQ_W'(SQUASH_DEPTH);
              state_nxt  = SQUASH;
            end
          end
        end
      end
      SQUASH: begin
        // Idle cycles carry no wrong-path instruction, so only valid entries count down.
        if (ex_valid) begin
          sq_cnt_nxt = sq_cnt - 1'b1;
          if (sq_cnt == SQ_W'(1)) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule
